bias_act_stage: RTL and testbench
=================================

Name: bias_act_stage

Overview:
Post-processing stage directly downstream of the MAC accelerator's AXI-Stream master output. It consumes one frame of HIDDEN_UNITS signed accumulator words, adds a per-unit bias from a local bias RAM, saturates to DATA_WIDTH and optionally applies ReLU. It emits the frame on its own AXI-Stream master with regenerated TLAST, and flags frame-length mismatches.

Parameters:
DATA_WIDTH, 32, width of stream words and bias words (two's-complement signed)
HIDDEN_UNITS, 64, words per frame; also bias RAM depth
IDX_BITS, $clog2(HIDDEN_UNITS), width of element index and bias address

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
bias_we  in  1  bias RAM write strobe
bias_addr  in  IDX_BITS  bias RAM write address
bias_wdata  in  DATA_WIDTH  bias value
relu_en  in  1  1 = clamp negative results to 0; sampled per beat at stage-2 compute
err_clr  in  1  clears sticky error flags
s_axis_tdata  in  DATA_WIDTH  accumulator word from MAC accelerator
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  input end of frame
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_WIDTH  activated result
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  output end of frame
frame_err  out  1  sticky: input TLAST disagreed with element count
sat_err  out  1  sticky: at least one bias add saturated

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, frame_err=0, sat_err=0, element index=0, both pipeline valids=0. Bias RAM contents are not reset.
- Pipeline: 2 stages, stall-all. advance = !v2 || m_axis_tready. s_axis_tready = advance (combinational from m_axis_tready; no combinational path from s_axis_tvalid).
- Accept (s_axis_tvalid && s_axis_tready): capture data, last, index into stage 1; present index as bias RAM read address with read-enable = advance.
- Stage 1 -> stage 2 on advance: sum = sign-extended data + sign-extended bias in DATA_WIDTH+1 bits. If sum > max signed -> max, set sat_err. If sum < min signed -> min, set sat_err. Then, if relu_en and result negative -> 0. Result is registered into m_axis_tdata.
- Latency: accepted beat appears on m_axis_tvalid 2 cycles later with no stalls. Throughput: 1 beat/cycle.
- m_axis_tdata/tlast are held stable while m_axis_tvalid && !m_axis_tready.
- Index: increments per accepted beat. Wraps to 0 after HIDDEN_UNITS-1 or on accepted s_axis_tlast, whichever comes first (resync).
- Output tlast = (index==HIDDEN_UNITS-1) || s_axis_tlast for that beat.
- frame_err is set on an accepted beat where s_axis_tlast != (index==HIDDEN_UNITS-1).
- Sticky flags: err_clr clears them. Same-cycle set and clear -> set wins.
- Bias RAM: 1 write port, 1 registered read port. Write ignored if bias_addr >= HIDDEN_UNITS. Same-cycle write and read to same address -> read returns old value. Writes permitted mid-frame.
- Stall with bubble: if v2=0, stage 1 moves forward regardless of m_axis_tready.
- Reset mid-frame: in-flight beats are discarded, index returns to 0, and the next accepted beat is element 0.

Decomposition:
- Package mac_pkg:
  - localparams for signed max/min of DATA_WIDTH
  - function sat_add(a, b) returning {sat flag, result}
  - function relu
- One sub-module bias_ram: simple dual-port, registered read with read-enable, IDX_BITS address, no reset on storage.

Test Plan:
- Bias[i]=i, relu_en=0, frame of 64 words data=-10 with tlast on word 63, m_axis_tready=1 -> outputs -10..53. tlast only on beat 63. First output 2 cycles after first accept. frame_err=0.
- relu_en=1, bias=0, data alternating +5/-5 -> outputs 5,0,5,0,... Bias=-6, data=+5 -> 0.
- Bias[0]=0x7FFFFFFF, data=1 -> output 0x7FFFFFFF, sat_err=1. Bias[1]=0x80000000, data=-1, relu_en=0 -> 0x80000000. Pulse err_clr -> sat_err=0.
- Random m_axis_tready (50%) and s_axis_tvalid gaps over 3 frames -> output sequence matches reference model bit-exactly, no drops or duplicates, data stable while stalled.
- s_axis_tlast on word 10 -> frame_err=1, output tlast on beat 10. Next beat is index 0 and gets bias[0].
- Assert rst mid-frame at word 20 with valids in flight -> m_axis_tvalid drops to 0 immediately. Subsequent full frame is correct with tlast on beat 63. Bias values written before reset are retained.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and arithmetic helpers for the MAC post-processing datapath.
package mac_pkg;

  localparam int unsigned PKG_DATA_WIDTH = 32;
  localparam logic [PKG_DATA_WIDTH-1:0] SMAX = {1'b0, {(PKG_DATA_WIDTH-1){1'b1}}};
  localparam logic [PKG_DATA_WIDTH-1:0] SMIN = {1'b1, {(PKG_DATA_WIDTH-1){1'b0}}};

  // Returns {saturated, result}; the extra sum bit exposes signed overflow.
  function automatic logic [PKG_DATA_WIDTH:0] sat_add(input logic [PKG_DATA_WIDTH-1:0] a,
                                                      input logic [PKG_DATA_WIDTH-1:0] b);
    logic [PKG_DATA_WIDTH:0] sum;
    sum = {a[PKG_DATA_WIDTH-1], a} + {b[PKG_DATA_WIDTH-1], b};
    if (sum[PKG_DATA_WIDTH] == sum[PKG_DATA_WIDTH-1]) sat_add = {1'b0, sum[PKG_DATA_WIDTH-1:0]};
    else if (sum[PKG_DATA_WIDTH])                     sat_add = {1'b1, SMIN};
    else                                              sat_add = {1'b1, SMAX};
  endfunction

  function automatic logic [PKG_DATA_WIDTH-1:0] relu(input logic [PKG_DATA_WIDTH-1:0] x);
    relu = x[PKG_DATA_WIDTH-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/bias_ram.sv
// Per-unit bias storage: one write port, one registered read port with enable.
module bias_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_BITS  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_ok_c;

  // Addresses past the last unit are dropped when the address space is larger than the RAM.
  if (DEPTH == (1 << ADDR_BITS)) begin : g_full
    assign wr_ok_c = 1'b1;
  end else begin : g_part
    assign wr_ok_c = ({1'b0, waddr} < (ADDR_BITS+1)'(DEPTH));
  end

  // Read-before-write: a same-address read sees the old contents.
  always_ff @(posedge clk) begin
    if (we && wr_ok_c) mem[waddr] <= wdata;
    if (re)            rdata      <= mem[raddr];
  end

endmodule

// File: rtl/bias_act_stage.sv
// Bias-add, saturate and optional ReLU stage on an AXI-Stream frame of accumulator words.
module bias_act_stage
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = PKG_DATA_WIDTH,
  parameter int unsigned HIDDEN_UNITS = 64,
  parameter int unsigned IDX_BITS     = $clog2(HIDDEN_UNITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bias_we,
  input  logic [IDX_BITS-1:0]   bias_addr,
  input  logic [DATA_WIDTH-1:0] bias_wdata,
  input  logic                  relu_en,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  frame_err,
  output logic                  sat_err
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(HIDDEN_UNITS - 1);

  logic                  advance_c, accept_c, idx_last_c;
  logic [IDX_BITS-1:0]   idx;
  logic                  v1, last1;
  logic [DATA_WIDTH-1:0] d1, bias_rd, act_c;
  logic [DATA_WIDTH:0]   add_c;

  // Whole pipeline stalls only when the output register is full and not drained.
  assign advance_c     = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = advance_c;
  assign accept_c      = s_axis_tvalid && advance_c;
  assign idx_last_c    = (idx == LAST_IDX);
  assign add_c         = sat_add(d1, bias_rd);
  assign act_c         = relu_en ? relu(add_c[DATA_WIDTH-1:0]) : add_c[DATA_WIDTH-1:0];

  bias_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (HIDDEN_UNITS),
    .ADDR_BITS  (IDX_BITS)
  ) u_bias_ram (
    .clk   (clk),
    .we    (bias_we),
    .waddr (bias_addr),
    .wdata (bias_wdata),
    .re    (advance_c),
    .raddr (idx),
    .rdata (bias_rd)
  );

  // Element index resyncs on whichever comes first: full count or input TLAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      frame_err <= 1'b0;
    end else begin
      if (accept_c) idx <= (s_axis_tlast || idx_last_c) ? '0 : idx + IDX_BITS'(1);
      if (accept_c && (s_axis_tlast != idx_last_c)) frame_err <= 1'b1;
      else if (err_clr)                             frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      d1    <= '0;
      last1 <= 1'b0;
    end else if (advance_c) begin
      v1 <= accept_c;
      if (accept_c) begin
        d1    <= s_axis_tdata;
        last1 <= idx_last_c || s_axis_tlast;
      end
    end
  end

  // Output register; contents only change on advance, so they hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      sat_err       <= 1'b0;
    end else begin
      if (advance_c) begin
        m_axis_tvalid <= v1;
        if (v1) begin
          m_axis_tdata <= act_c;
          m_axis_tlast <= last1;
        end
      end
      if (advance_c && v1 && add_c[DATA_WIDTH]) sat_err <= 1'b1;
      else if (err_clr)                         sat_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bias_act_stage.sv
// Directed bench for bias_act_stage: bias ramp, ReLU, saturation, stalls, short frame, reset.
module tb_bias_act_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bias_we = 1'b0;
  logic [5:0]  bias_addr = '0;
  logic [31:0] bias_wdata = '0;
  logic        relu_en = 1'b0, err_clr = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [31:0] m_data;
  logic        m_valid, m_last, m_ready = 1'b1;
  logic        frame_err, sat_err;

  int total = 0, bad = 0, cyc = 0, first_acc_cyc = -1, stall_viol = 0;
  logic [31:0] bias_m [64];
  logic [31:0] obs_d[$];
  logic        obs_l[$];
  int          obs_c[$];

  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;

  always #5 clk = ~clk;

  bias_act_stage dut (
    .clk(clk), .rst(rst), .bias_we(bias_we), .bias_addr(bias_addr), .bias_wdata(bias_wdata),
    .relu_en(relu_en), .err_clr(err_clr),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last), .m_axis_tready(m_ready),
    .frame_err(frame_err), .sat_err(sat_err)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: logs handshakes and flags any change while stalled.
  initial begin : monitor
    logic prev_stall, prev_l;
    logic [31:0] prev_d;
    prev_stall = 1'b0; prev_l = 1'b0; prev_d = '0;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 1'b0;
      else begin
        if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_d || m_last !== prev_l)) stall_viol++;
        prev_stall = m_valid && !m_ready;
        prev_d = m_data; prev_l = m_last;
        if (m_valid && m_ready) begin
          obs_d.push_back(m_data); obs_l.push_back(m_last); obs_c.push_back(cyc);
        end
      end
    end
  end

  function automatic logic [31:0] ref_calc(input logic [31:0] d, input logic [31:0] b, input logic r);
    longint s;
    s = longint'($signed(d)) + longint'($signed(b));
    if (s > LMAX) s = LMAX;
    if (s < LMIN) s = LMIN;
    if (r && s < 0) s = 0;
    return s[31:0];
  endfunction

  task automatic write_bias(input int a, input logic [31:0] v);
    bias_we = 1'b1; bias_addr = 6'(a); bias_wdata = v; bias_m[a] = v;
    @(posedge clk); #1;
    bias_we = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic clear_obs();
    obs_d.delete(); obs_l.delete(); obs_c.delete();
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    logic acc = 1'b0;
    int   n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = s_ready;
      if (acc && first_acc_cyc < 0) first_acc_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout got=ready_low want=accept");
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (m_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid got=%b want=0", m_valid); end
    total++; if (m_data !== 32'h0)   begin bad++; $display("FAIL rst_data got=%h want=0", m_data); end
    total++; if (m_last !== 1'b0)    begin bad++; $display("FAIL rst_last got=%b want=0", m_last); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err got=%b want=0", frame_err); end
    total++; if (sat_err !== 1'b0)   begin bad++; $display("FAIL rst_sat_err got=%b want=0", sat_err); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    total++; if (s_ready !== 1'b1)   begin bad++; $display("FAIL rst_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_bias_ramp();
    for (int i = 0; i < 64; i++) write_bias(i, 32'(i));
    relu_en = 1'b0; m_ready = 1'b1; clear_obs(); first_acc_cyc = -1;
    for (int i = 0; i < 64; i++) send(32'(-10), i == 63);
    for (int k = 0; k < 300 && obs_d.size() < 64; k++) begin @(posedge clk); #1; end
    total++; if (obs_d.size() != 64) begin bad++; $display("FAIL ramp_count got=%0d want=64", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 64; i++) begin
      total++; if (obs_d[i] !== 32'(i - 10)) begin bad++; $display("FAIL ramp_data[%0d] got=%h want=%h", i, obs_d[i], 32'(i - 10)); end
      total++; if (obs_l[i] !== (i == 63))   begin bad++; $display("FAIL ramp_last[%0d] got=%b want=%b", i, obs_l[i], i == 63); end
    end
    if (obs_c.size() > 0) begin
      total++; if (obs_c[0] - first_acc_cyc != 2) begin bad++; $display("FAIL ramp_latency got=%0d want=2", obs_c[0] - first_acc_cyc); end
    end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ramp_frame_err got=%b want=0", frame_err); end
    total++; if (sat_err !== 1'b0)   begin bad++; $display("FAIL ramp_sat_err got=%b want=0", sat_err); end
  endtask

  task automatic test_relu();
    relu_en = 1'b1; m_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 64; i++) write_bias(i, (p == 0) ? 32'h0 : 32'(-6));
      clear_obs();
      for (int i = 0; i < 64; i++) send((p == 1 || i % 2 == 0) ? 32'd5 : 32'(-5), i == 63);
      for (int k = 0; k < 300 && obs_d.size() < 64; k++) begin @(posedge clk); #1; end
      total++; if (obs_d.size() != 64) begin bad++; $display("FAIL relu_count[%0d] got=%0d want=64", p, obs_d.size()); end
      for (int i = 0; i < obs_d.size() && i < 64; i++) begin
        logic [31:0] e;
        e = (p == 0 && i % 2 == 0) ? 32'd5 : 32'd0;
        total++; if (obs_d[i] !== e) begin bad++; $display("FAIL relu_data[%0d][%0d] got=%h want=%h", p, i, obs_d[i], e); end
      end
    end
    relu_en = 1'b0;
    total++; if (sat_err !== 1'b0) begin bad++; $display("FAIL relu_sat_err got=%b want=0", sat_err); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 64; i++) write_bias(i, 32'h0);
    write_bias(0, 32'h7FFF_FFFF);
    write_bias(1, 32'h8000_0000);
    relu_en = 1'b0; m_ready = 1'b1; clear_obs();
    for (int i = 0; i < 64; i++) send((i == 0) ? 32'd1 : (i == 1) ? 32'hFFFF_FFFF : 32'(i), i == 63);
    for (int k = 0; k < 300 && obs_d.size() < 64; k++) begin @(posedge clk); #1; end
    total++; if (obs_d.size() != 64) begin bad++; $display("FAIL sat_count got=%0d want=64", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 64; i++) begin
      logic [31:0] e;
      e = (i == 0) ? 32'h7FFF_FFFF : (i == 1) ? 32'h8000_0000 : 32'(i);
      total++; if (obs_d[i] !== e) begin bad++; $display("FAIL sat_data[%0d] got=%h want=%h", i, obs_d[i], e); end
    end
    total++; if (sat_err !== 1'b1)   begin bad++; $display("FAIL sat_flag got=%b want=1", sat_err); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL sat_frame_err got=%b want=0", frame_err); end
    pulse_clr();
    total++; if (sat_err !== 1'b0)   begin bad++; $display("FAIL sat_clear got=%b want=0", sat_err); end
  endtask

  task automatic test_random_stall();
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    bit          done = 1'b0;
    for (int i = 0; i < 64; i++) write_bias(i, $urandom);
    write_bias(5, 32'h7FFF_FFFF);
    write_bias(6, 32'h8000_0000);
    relu_en = 1'b0; clear_obs(); stall_viol = 0;
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int i = 0; i < 64; i++) begin
            logic [31:0] d;
            d = (i == 5) ? 32'h4000_0000 : (i == 6) ? 32'hC000_0000 : $urandom;
            exp_d.push_back(ref_calc(d, bias_m[i], 1'b0)); exp_l.push_back(i == 63);
            send(d, i == 63);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          end
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
    join
    for (int k = 0; k < 300 && obs_d.size() < 192; k++) begin @(posedge clk); #1; end
    total++; if (obs_d.size() != 192) begin bad++; $display("FAIL rand_count got=%0d want=192", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 192; i++) begin
      total++; if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i])
        begin bad++; $display("FAIL rand_beat[%0d] got=%h/%b want=%h/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]); end
    end
    total++; if (stall_viol != 0)  begin bad++; $display("FAIL rand_stall_stable got=%0d want=0", stall_viol); end
    total++; if (sat_err !== 1'b1) begin bad++; $display("FAIL rand_sat_err got=%b want=1", sat_err); end
    pulse_clr();
  endtask

  task automatic test_short_frame();
    for (int i = 0; i < 64; i++) write_bias(i, 32'(1000 + i));
    relu_en = 1'b0; m_ready = 1'b1;
    pulse_clr();
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL short_pre_err got=%b want=0", frame_err); end
    clear_obs();
    for (int i = 0; i < 11; i++) send(32'(i), i == 10);
    for (int i = 0; i < 64; i++) send(32'd7, i == 63);
    for (int k = 0; k < 300 && obs_d.size() < 75; k++) begin @(posedge clk); #1; end
    total++; if (obs_d.size() != 75) begin bad++; $display("FAIL short_count got=%0d want=75", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 75; i++) begin
      logic [31:0] e;
      logic        el;
      e  = (i < 11) ? 32'(1000 + 2 * i) : 32'(1007 + (i - 11));
      el = (i == 10) || (i == 74);
      total++; if (obs_d[i] !== e || obs_l[i] !== el)
        begin bad++; $display("FAIL short_beat[%0d] got=%h/%b want=%h/%b", i, obs_d[i], obs_l[i], e, el); end
    end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL short_frame_err got=%b want=1", frame_err); end
    pulse_clr();
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 64; i++) write_bias(i, 32'(3 * i - 50));
    relu_en = 1'b0; m_ready = 1'b1; clear_obs();
    for (int i = 0; i < 20; i++) send(32'(100 + i), 1'b0);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mid_inflight got=%b want=1", m_valid); end
    rst = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0)   begin bad++; $display("FAIL mid_rst_valid got=%b want=0", m_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_rst_frame_err got=%b want=0", frame_err); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    clear_obs();
    for (int i = 0; i < 64; i++) send(32'(2 * i), i == 63);
    for (int k = 0; k < 300 && obs_d.size() < 64; k++) begin @(posedge clk); #1; end
    total++; if (obs_d.size() != 64) begin bad++; $display("FAIL mid_count got=%0d want=64", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 64; i++) begin
      logic [31:0] e;
      e = 32'(5 * i - 50);
      total++; if (obs_d[i] !== e || obs_l[i] !== (i == 63))
        begin bad++; $display("FAIL mid_beat[%0d] got=%h/%b want=%h/%b", i, obs_d[i], obs_l[i], e, i == 63); end
    end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_frame_err got=%b want=0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_bias_ramp();
    test_relu();
    test_saturation();
    test_random_stall();
    test_short_frame();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
